// File: rtl/mult_share_arb.sv
// Two-requester round-robin front end for one shared 8x8 multiplier.
// Operands are registered, the product is registered and held until the winner takes it.
module mult_share_arb #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned RES_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [OP_W-1:0]  req0_a_i,
  input  logic [OP_W-1:0]  req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [OP_W-1:0]  req1_a_i,
  input  logic [OP_W-1:0]  req1_b_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [RES_W-1:0] rsp_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);

  typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_id_q, gnt_id_d;
  logic [OP_W-1:0]    op_a_q, op_a_d;
  logic [OP_W-1:0]    op_b_q, op_b_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [RES_W-1:0]   product;
  logic               gnt0, gnt1, rsp_hs;

  // Carry-save reduction of the partial products, one final carry-propagate add.
  // Bits carried out of the top are dropped: the true product always fits RES_W.
  always_comb begin
    logic [RES_W-1:0] s, c, pp, s_n;
    s = '0;
    c = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      pp  = op_b_q[i] ? (RES_W'(op_a_q) << i) : '0;
      s_n = s ^ c ^ pp;
      c   = ((s & c) | (s & pp) | (c & pp)) << 1;
      s   = s_n;
    end
    product = s + c;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0   = (state_q == StIdle) && req0_valid_i && (!req1_valid_i || last_grant_q);
    gnt1   = (state_q == StIdle) && req1_valid_i && (!req0_valid_i || !last_grant_q);
    rsp_hs = (state_q == StResp) && (gnt_id_q ? rsp1_ready_i : rsp0_ready_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_data_q   <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_data_q   <= rsp_data_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt0 || gnt1) state_d = StMul;
      StMul:   state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_data_d   = rsp_data_q;
    op_count_d   = op_count_q;
    if (gnt0 || gnt1) begin
      gnt_id_d = gnt1;
      op_a_d   = gnt1 ? req1_a_i : req0_a_i;
      op_b_d   = gnt1 ? req1_b_i : req0_b_i;
    end
    if (state_q == StMul) rsp_data_d = product;
    if (rsp_hs) begin
      last_grant_d = gnt_id_q;
      op_count_d   = op_count_q + 1'b1;
    end
  end

  // Ready is masked during reset so a waiting requester is never told it was taken.
  always_comb begin
    req0_ready_o = gnt0 && rst_n;
    req1_ready_o = gnt1 && rst_n;
    rsp0_valid_o = (state_q == StResp) && !gnt_id_q;
    rsp1_valid_o = (state_q == StResp) && gnt_id_q;
    busy_o       = (state_q != StIdle);
    rsp_data_o   = rsp_data_q;
    op_count_o   = op_count_q;
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed and randomised checks for mult_share_arb: arbitration, latency,
// products, backpressure, reset mid-operation and counter wrap.
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp_data, op_count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  mult_share_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp_data_o   (rsp_data),
    .busy_o       (busy),
    .op_count_o   (op_count)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  // Drives one transaction for requester id; returns the product and ok=0 on a timeout.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output logic ok);
    int n;
    ok = 1'b1;
    prod = '0;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    n = 0;
    while (!(id ? rsp1_valid : rsp0_valid) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) ok = 1'b0;
    prod = rsp_data;
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    tests++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {rsp0_valid, rsp1_valid, busy});
    end
    tests++;
    if (rsp_data !== 16'h0000) begin
      fails++; $display("FAIL reset_data: got %h want 0000", rsp_data);
    end
    tests++;
    if (op_count !== 16'h0000) begin
      fails++; $display("FAIL reset_count: got %h want 0000", op_count);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h0D;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL single_grant: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests++;
    if ({busy, rsp0_valid, req0_ready} !== 3'b100) begin
      fails++; $display("FAIL single_mul: busy/rsp0_valid/req0_ready got %b want 100",
                        {busy, rsp0_valid, req0_ready});
    end
    @(negedge clk);
    #1;
    tests++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
      fails++; $display("FAIL single_rsp_valid: got %b want 10", {rsp0_valid, rsp1_valid});
    end
    tests++;
    if (rsp_data !== 16'h009C) begin
      fails++; $display("FAIL single_data: got %h want 009c", rsp_data);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    exp_count = 1;
    tests++;
    if (op_count !== 16'd1 || busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL single_done: count=%h busy=%b valid=%b want 0001 0 0",
                        op_count, busy, rsp0_valid);
    end
  endtask

  task automatic test_contention();
    int         gcnt;
    logic [3:0] gseq;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h02;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    gcnt = 0;
    gseq = '0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (req0_ready || req1_ready) begin
        if (gcnt < 4) gseq[gcnt] = req1_ready;
        gcnt++;
      end
      if (rsp0_valid) begin
        tests++;
        if (rsp_data !== 16'hFE01) begin
          fails++; $display("FAIL contention_rsp0: got %h want fe01", rsp_data);
        end
      end
      if (rsp1_valid) begin
        tests++;
        if (rsp_data !== 16'h0100) begin
          fails++; $display("FAIL contention_rsp1: got %h want 0100", rsp_data);
        end
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    exp_count = 4;
    tests++;
    if (gcnt !== 4) begin
      fails++; $display("FAIL contention_grants: got %0d want 4", gcnt);
    end
    tests++;
    if (gseq !== 4'b1010) begin
      fails++; $display("FAIL contention_order: got %b want 1010 (lsb first)", gseq);
    end
    tests++;
    if (op_count !== 16'd4) begin
      fails++; $display("FAIL contention_count: got %0d want 4", op_count);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h09;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    #1;
    tests++;
    if (req1_ready !== 1'b1) begin
      fails++; $display("FAIL bp_grant: req1_ready got %b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03;
    @(negedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      tests++;
      if ({rsp1_valid, rsp0_valid, busy, req0_ready, req1_ready} !== 5'b10100 ||
          rsp_data !== 16'h003F) begin
        fails++; $display("FAIL bp_hold[%0d]: flags got %b want 10100, data got %h want 003f",
                          i, {rsp1_valid, rsp0_valid, busy, req0_ready, req1_ready}, rsp_data);
      end
      if (i < 10) begin @(negedge clk); #1; end
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_count++;
    tests++;
    if ({busy, rsp1_valid, req0_ready} !== 3'b001 || op_count !== exp_count[15:0]) begin
      fails++; $display("FAIL bp_release: busy/rsp1/req0_ready got %b want 001, count %0d want %0d",
                        {busy, rsp1_valid, req0_ready}, op_count, exp_count);
    end
    req0_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_boundary();
    logic [15:0] p;
    logic        ok;
    run_op(1'b0, 8'h00, 8'hAB, p, ok);
    tests++;
    if (!ok || p !== 16'h0000) begin
      fails++; $display("FAIL bnd_zero: got %h ok=%b want 0000", p, ok);
    end
    run_op(1'b1, 8'h01, 8'hFF, p, ok);
    tests++;
    if (!ok || p !== 16'h00FF) begin
      fails++; $display("FAIL bnd_one: got %h ok=%b want 00ff", p, ok);
    end
    run_op(1'b0, 8'hAA, 8'h55, p, ok);
    tests++;
    if (!ok || p !== 16'h3872) begin
      fails++; $display("FAIL bnd_aa55: got %h ok=%b want 3872", p, ok);
    end
    exp_count += 3;
    tests++;
    if (op_count !== exp_count[15:0]) begin
      fails++; $display("FAIL bnd_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    for (int ph = 1; ph <= 2; ph++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h05;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (ph) @(posedge clk);
      #1;
      if (ph == 2) begin
        tests++;
        if (rsp0_valid !== 1'b1) begin
          fails++; $display("FAIL rstmid_pre: rsp0_valid got %b want 1", rsp0_valid);
        end
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000 ||
          rsp_data !== 16'h0000 || op_count !== 16'h0000) begin
        fails++; $display("FAIL rstmid_out[%0d]: flags got %b want 00000, data %h count %h want 0",
                          ph, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy},
                          rsp_data, op_count);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (rsp0_valid || rsp1_valid || busy) bad = 1'b1;
      end
      tests++;
      if (bad !== 1'b0) begin
        fails++; $display("FAIL rstmid_quiet[%0d]: got activity=%b want 0", ph, bad);
      end
    end
    exp_count = 0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL rstmid_first: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [15:0] p;
    logic        ok;
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    #1;
    tests++;
    if (op_count !== 16'hFFFE) begin
      fails++; $display("FAIL wrap_preload: got %h want fffe", op_count);
    end
    run_op(1'b1, 8'h10, 8'h10, p, ok);
    tests++;
    if (!ok || op_count !== 16'hFFFF || p !== 16'h0100) begin
      fails++; $display("FAIL wrap_ffff: count %h prod %h ok=%b want ffff 0100 1", op_count, p, ok);
    end
    run_op(1'b0, 8'h02, 8'h02, p, ok);
    tests++;
    if (!ok || op_count !== 16'h0000 || p !== 16'h0004) begin
      fails++; $display("FAIL wrap_zero: count %h prod %h ok=%b want 0000 0004 1", op_count, p, ok);
    end
  endtask

  task automatic test_random();
    int unsigned done, cyc;
    int          st_m;
    logic        last_m, gid_m, g0, g1, v0, v1, r0, r1;
    logic [7:0]  a0, b0, a1, b1;
    logic [15:0] prod_m;
    apply_reset();
    st_m = 0; last_m = 1'b1; gid_m = 1'b0; prod_m = '0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    done = 0; cyc = 0;
    while (done < 10000 && cyc < 60000) begin
      @(negedge clk);
      if (v0) begin if ($urandom_range(0, 9) == 0) v0 = 1'b0; end
      else if ($urandom_range(0, 9) < 8) begin v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); end
      if (v1) begin if ($urandom_range(0, 9) == 0) v1 = 1'b0; end
      else if ($urandom_range(0, 9) < 8) begin v1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom); end
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      rsp0_ready = r0; rsp1_ready = r1;
      #1;
      g0 = (st_m == 0) && v0 && (!v1 || last_m);
      g1 = (st_m == 0) && v1 && (!v0 || !last_m);
      tests++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !==
          {g0, g1, (st_m == 2) && !gid_m, (st_m == 2) && gid_m}) begin
        fails++; $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc,
                          {req0_ready, req1_ready, rsp0_valid, rsp1_valid},
                          {g0, g1, (st_m == 2) && !gid_m, (st_m == 2) && gid_m});
      end
      if (st_m == 2) begin
        tests++;
        if (rsp_data !== prod_m) begin
          fails++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, rsp_data, prod_m);
        end
      end
      case (st_m)
        0: if (g0 || g1) begin
             gid_m  = g1;
             prod_m = g1 ? a1 * b1 : a0 * b0;
             st_m   = 1;
           end
        1: st_m = 2;
        default: if (gid_m ? r1 : r0) begin
             last_m = gid_m;
             st_m   = 0;
             done++;
             exp_count++;
           end
      endcase
      if (g0) v0 = 1'b0;
      if (g1) v1 = 1'b0;
      cyc++;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    tests++;
    if (done < 10000) begin
      fails++; $display("FAIL rnd_progress: got %0d products want 10000", done);
    end
    tests++;
    if (op_count !== exp_count[15:0]) begin
      fails++; $display("FAIL rnd_count: got %0d want %0d", op_count, exp_count[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
